// File: rtl/tmds_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : tmds_decoder_if
// Description : Symbol/result bundle for one TMDS receive channel.
//               master : symbol source / result consumer (deserializer side)
//               slave  : the decoder itself
//               raw_symbol   - unaligned 10-bit word from the deserializer
//               data         - decoded pixel byte
//               control_data - decoded control code {C1,C0}
//               blanking     - current symbol is a control token
//               data_valid   - outputs are meaningful (decoder is locked)
//               locked       - alignment state is LOCKED
//               bit_offset   - current window offset, 0..9
// Revision    : 1.0 - initial release
// ============================================================================
interface tmds_decoder_if;
  logic [9:0] raw_symbol;
  logic [7:0] data;
  logic [1:0] control_data;
  logic       blanking;
  logic       data_valid;
  logic       locked;
  logic [3:0] bit_offset;

  modport master (
    output raw_symbol,
    input  data, control_data, blanking, data_valid, locked, bit_offset
  );

  modport slave (
    input  raw_symbol,
    output data, control_data, blanking, data_valid, locked, bit_offset
  );
endinterface
`default_nettype wire

// File: rtl/tmds_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tmds_decoder
// Description : TMDS receive decoder for one HDMI/DVI channel. Bit-slips a
//               10-bit window across two consecutive deserializer words until
//               a run of control tokens is seen, then decodes each aligned
//               symbol into pixel data or a control code plus blanking flag.
// Ports       : pix_clock - pixel clock, all state on its rising edge
//               reset_n   - asynchronous active-low reset
//               bus       - tmds_decoder_if.slave (raw symbol in, results out)
// Revision    : 1.0 - initial release
// ============================================================================
module tmds_decoder #(
  parameter int SYNC_THRESH    = 8,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int LOCK_TIMEOUT   = 8192
) (
  input  wire           pix_clock,
  input  wire           reset_n,
  tmds_decoder_if.slave bus
);

  localparam int c_run_w = $clog2(SYNC_THRESH) + 1;
  localparam int c_tmo_w = $clog2(SEARCH_TIMEOUT) + 1;
  localparam int c_gap_w = $clog2(LOCK_TIMEOUT) + 1;

  // "count + 1 == threshold" is evaluated as "count == threshold - 1"; the
  // counters are cleared before they could ever wrap, so both are equivalent.
  localparam logic [c_run_w-1:0] c_run_last = c_run_w'(SYNC_THRESH - 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(SEARCH_TIMEOUT - 1);
  localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]         c_last_ofs = 4'd9;

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [9:0]           r_prev_raw;
  logic [3:0]           r_bit_offset, w_bit_offset_nxt;
  logic [c_run_w-1:0]   r_run_cnt, w_run_cnt_nxt;
  logic [c_tmo_w-1:0]   r_tmo_cnt, w_tmo_cnt_nxt;
  logic [c_gap_w-1:0]   r_gap_cnt, w_gap_cnt_nxt;

  logic [9:0]           w_window;
  logic                 w_is_token;
  logic [1:0]           w_token_code;
  logic [7:0]           w_d;
  logic [7:0]           w_dec;

  logic [7:0]           r_data;
  logic [1:0]           r_ctrl;
  logic                 r_blank;
  logic                 r_valid;

  // Older word sits in the low half, so offset 0 selects prev_raw and each
  // increment pulls one more bit in from the newer word.
  assign w_window = 10'({bus.raw_symbol, r_prev_raw} >> r_bit_offset);

  always_comb begin
    w_is_token   = 1'b1;
    w_token_code = 2'b00;
    case (w_window)
      10'b1101010100: w_token_code = 2'b00;
      10'b0010101011: w_token_code = 2'b01;
      10'b0101010100: w_token_code = 2'b10;
      10'b1010101011: w_token_code = 2'b11;
      default:        w_is_token   = 1'b0;
    endcase
  end

  // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8).
  assign w_d      = w_window[9] ? ~w_window[7:0] : w_window[7:0];
  assign w_dec[0] = w_d[0];

  for (genvar gi = 1; gi < 8; gi++) begin : g_dec
    assign w_dec[gi] = w_window[8] ?  (w_d[gi] ^ w_d[gi-1])
                                  : ~(w_d[gi] ^ w_d[gi-1]);
  end

  // --------------------------------------------------------------------------
  // Alignment FSM: next-state and counter logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_bit_offset_nxt = r_bit_offset;
    w_run_cnt_nxt    = r_run_cnt;
    w_tmo_cnt_nxt    = r_tmo_cnt;
    w_gap_cnt_nxt    = r_gap_cnt;

    case (r_state)
      ST_SEARCH: begin
        w_tmo_cnt_nxt = r_tmo_cnt + c_tmo_w'(1);
        w_run_cnt_nxt = w_is_token ? (r_run_cnt + c_run_w'(1)) : '0;
        // Lock wins over a slip landing on the same cycle.
        if (w_is_token && (r_run_cnt == c_run_last)) begin
          w_state_nxt   = ST_LOCKED;
          w_run_cnt_nxt = '0;
          w_tmo_cnt_nxt = '0;
          w_gap_cnt_nxt = '0;
        end else if (r_tmo_cnt == c_tmo_last) begin
          w_bit_offset_nxt = (r_bit_offset == c_last_ofs) ? 4'd0
                                                          : r_bit_offset + 4'd1;
          w_run_cnt_nxt    = '0;
          w_tmo_cnt_nxt    = '0;
        end
      end

      ST_LOCKED: begin
        if (w_is_token) begin
          w_gap_cnt_nxt = '0;
        end else if (r_gap_cnt == c_gap_last) begin
          // Drop lock but keep the offset: the search resumes where it was.
          w_state_nxt   = ST_SEARCH;
          w_run_cnt_nxt = '0;
          w_tmo_cnt_nxt = '0;
          w_gap_cnt_nxt = '0;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + c_gap_w'(1);
        end
      end

      default: w_state_nxt = ST_SEARCH;
    endcase
  end

  always_ff @(posedge pix_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_SEARCH;
      r_prev_raw   <= '0;
      r_bit_offset <= '0;
      r_run_cnt    <= '0;
      r_tmo_cnt    <= '0;
      r_gap_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev_raw   <= bus.raw_symbol;
      r_bit_offset <= w_bit_offset_nxt;
      r_run_cnt    <= w_run_cnt_nxt;
      r_tmo_cnt    <= w_tmo_cnt_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Output register: gated by the state being entered this edge so that the
  // locking token itself and data_valid appear on the same update.
  // --------------------------------------------------------------------------
  always_ff @(posedge pix_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_ctrl  <= '0;
      r_blank <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      r_valid <= (w_state_nxt == ST_LOCKED);
      if (w_state_nxt != ST_LOCKED) begin
        r_data  <= '0;
        r_ctrl  <= '0;
        r_blank <= 1'b1;
      end else if (w_is_token) begin
        r_data  <= '0;
        r_ctrl  <= w_token_code;
        r_blank <= 1'b1;
      end else begin
        // control_data keeps the last token's code through active video.
        r_data  <= w_dec;
        r_blank <= 1'b0;
      end
    end
  end

  assign bus.data         = r_data;
  assign bus.control_data = r_ctrl;
  assign bus.blanking     = r_blank;
  assign bus.data_valid   = r_valid;
  assign bus.locked       = (r_state == ST_LOCKED);
  assign bus.bit_offset   = r_bit_offset;

endmodule
`default_nettype wire

// File: tb/tb_tmds_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_tmds_decoder
// Description : Directed self-checking bench for tmds_decoder. Two instances
//               share clock, reset and symbol stream: dut_a keeps the long
//               search timeout (lock, threshold, data decode, lock loss);
//               dut_b uses a 16-cycle search timeout (bit-slip behaviour).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tmds_decoder;

  localparam logic [9:0] c_tok00 = 10'b1101010100;
  localparam logic [9:0] c_tok11 = 10'b1010101011;
  // Constant streams whose tokens only appear at offset 3 (code 11) and at
  // offset 5 (code 00): each is the token rotated left by that offset.
  localparam logic [9:0] c_w3    = 10'b0101011101;
  localparam logic [9:0] c_w5    = 10'b1010011010;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  tmds_decoder_if if_a ();
  tmds_decoder_if if_b ();

  tmds_decoder #(
    .SYNC_THRESH    (8),
    .SEARCH_TIMEOUT (4096),
    .LOCK_TIMEOUT   (32)
  ) dut_a (
    .pix_clock (clk),
    .reset_n   (reset_n),
    .bus       (if_a)
  );

  tmds_decoder #(
    .SYNC_THRESH    (8),
    .SEARCH_TIMEOUT (16),
    .LOCK_TIMEOUT   (32)
  ) dut_b (
    .pix_clock (clk),
    .reset_n   (reset_n),
    .bus       (if_b)
  );

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else
      n_pass++;
  endtask

  // Drive one symbol, let one rising edge consume it, sample 1 ns later.
  task automatic step(input logic [9:0] sym);
    if_a.raw_symbol = sym;
    if_b.raw_symbol = sym;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    step(10'h000);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    if_a.raw_symbol = '0;
    if_b.raw_symbol = '0;
    @(posedge clk);
    #1;

    // ---------------- reset state ----------------
    repeat (3) step(10'($urandom));
    check_eq("rst_locked",   16'(if_a.locked),       16'd0);
    check_eq("rst_valid",    16'(if_a.data_valid),   16'd0);
    check_eq("rst_blank",    16'(if_a.blanking),     16'd1);
    check_eq("rst_data",     16'(if_a.data),         16'd0);
    check_eq("rst_ctrl",     16'(if_a.control_data), 16'd0);
    check_eq("rst_offset",   16'(if_a.bit_offset),   16'd0);
    check_eq("rst_b_offset", 16'(if_b.bit_offset),   16'd0);
    reset_n = 1'b1;

    // ---------------- threshold edge: 7 tokens, data, 8 tokens ----------------
    repeat (7) step(c_tok00);
    step(10'h100);
    repeat (8) step(c_tok00);
    check_eq("thr_no_lock", 16'(if_a.locked), 16'd0);
    step(c_tok00);
    check_eq("thr_lock",    16'(if_a.locked), 16'd1);

    // ---------------- lock at offset 0 and data decode ----------------
    reset_pulse();
    check_eq("lock_rst", 16'(if_a.locked), 16'd0);
    repeat (8) step(c_tok00);
    check_eq("lock_pre", 16'(if_a.locked), 16'd0);
    step(10'h100);
    check_eq("lock_locked", 16'(if_a.locked),       16'd1);
    check_eq("lock_valid",  16'(if_a.data_valid),   16'd1);
    check_eq("lock_blank",  16'(if_a.blanking),     16'd1);
    check_eq("lock_ctrl",   16'(if_a.control_data), 16'd0);
    step(10'h200);
    check_eq("dec100_blank", 16'(if_a.blanking), 16'd0);
    check_eq("dec100_data",  16'(if_a.data),     16'h00);
    step(c_tok11);
    check_eq("dec200_blank", 16'(if_a.blanking), 16'd0);
    check_eq("dec200_data",  16'(if_a.data),     16'hFF);

    // ---------------- control hold, then lock loss after 32 data ----------------
    step(10'h100);
    check_eq("tok11_blank", 16'(if_a.blanking),     16'd1);
    check_eq("tok11_ctrl",  16'(if_a.control_data), 16'd3);
    check_eq("tok11_data",  16'(if_a.data),         16'd0);
    step(10'h100);
    check_eq("hold_blank", 16'(if_a.blanking),     16'd0);
    check_eq("hold_ctrl",  16'(if_a.control_data), 16'd3);
    repeat (30) step(10'h100);
    check_eq("gap31_locked", 16'(if_a.locked),     16'd1);
    check_eq("gap31_valid",  16'(if_a.data_valid), 16'd1);
    step(10'h100);
    check_eq("loss_locked", 16'(if_a.locked),       16'd0);
    check_eq("loss_valid",  16'(if_a.data_valid),   16'd0);
    check_eq("loss_blank",  16'(if_a.blanking),     16'd1);
    check_eq("loss_ctrl",   16'(if_a.control_data), 16'd0);
    check_eq("loss_offset", 16'(if_a.bit_offset),   16'd0);
    repeat (8) step(c_tok00);
    check_eq("relock_pre", 16'(if_a.locked), 16'd0);
    step(c_tok00);
    check_eq("relock",     16'(if_a.locked), 16'd1);

    // ---------------- slip search to offset 3 (dut_b) ----------------
    reset_pulse();
    repeat (15) step(c_w3);
    check_eq("slip_ofs0", 16'(if_b.bit_offset), 16'd0);
    step(c_w3);
    check_eq("slip_ofs1", 16'(if_b.bit_offset), 16'd1);
    repeat (16) step(c_w3);
    check_eq("slip_ofs2", 16'(if_b.bit_offset), 16'd2);
    repeat (16) step(c_w3);
    check_eq("slip_ofs3", 16'(if_b.bit_offset), 16'd3);
    repeat (7) step(c_w3);
    check_eq("slip_pre_lock", 16'(if_b.locked), 16'd0);
    step(c_w3);
    check_eq("slip_locked", 16'(if_b.locked),       16'd1);
    check_eq("slip_valid",  16'(if_b.data_valid),   16'd1);
    check_eq("slip_ctrl",   16'(if_b.control_data), 16'd3);
    repeat (44) step(c_w3);
    check_eq("slip_stay_ofs", 16'(if_b.bit_offset), 16'd3);
    check_eq("slip_stay_lck", 16'(if_b.locked),     16'd1);

    // ---------------- lock at offset 5, async reset, relock ----------------
    reset_pulse();
    repeat (80) step(c_w5);
    check_eq("ofs5_offset", 16'(if_b.bit_offset), 16'd5);
    repeat (7) step(c_w5);
    check_eq("ofs5_pre", 16'(if_b.locked), 16'd0);
    step(c_w5);
    check_eq("ofs5_locked", 16'(if_b.locked),       16'd1);
    check_eq("ofs5_ctrl",   16'(if_b.control_data), 16'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_locked", 16'(if_b.locked),     16'd0);
    check_eq("arst_offset", 16'(if_b.bit_offset), 16'd0);
    check_eq("arst_valid",  16'(if_b.data_valid), 16'd0);
    check_eq("arst_blank",  16'(if_b.blanking),   16'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (8) step(c_tok00);
    check_eq("arst_relock_pre", 16'(if_b.locked), 16'd0);
    step(c_tok00);
    check_eq("arst_relock",     16'(if_b.locked),     16'd1);
    check_eq("arst_relock_ofs", 16'(if_b.bit_offset), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
